// File: rtl/counter_pkg.sv
// Shared types for the modulo-N up/down counter.
package counter_pkg;

    // Count direction as presented on the mode pin.
    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_mode_e;

    // Run/halt state of the counter.
    typedef enum logic {
        ST_RUN,
        ST_DONE
    } cnt_state_e;

endpackage : counter_pkg

// File: rtl/mod_n_updown_counter.sv
// Loadable up/down modulo-N counter with wrap or one-shot (halt) behaviour,
// cascade carry/borrow pulses, out-of-range load rejection and a sticky done.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_RUN  | counting allowed; en steps data_out toward the terminal count
// ST_DONE | halted at terminal count in one-shot mode; only a valid load or
//         | rst leaves this state, en/mode/wrap_en are ignored
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             load,
    input  logic             wrap_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             carry,
    output logic             borrow,
    output logic             load_err,
    output logic             done
);

    // The modulus is held one bit wider than the count so that
    // MODULUS == 2**WIDTH is representable for the load range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    // Reject illegal WIDTH/MODULUS combinations at elaboration.
    generate
        if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
            $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    cnt_state_e       state_q, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic             carry_q, carry_nxt;
    logic             borrow_q, borrow_nxt;
    logic             load_err_q, load_err_nxt;

    cnt_mode_e        dir;
    logic             load_ok;
    logic             at_max;
    logic             at_zero;

    assign dir     = cnt_mode_e'(mode);
    assign load_ok = ({1'b0, data_in} < MOD_EXT);
    assign at_max  = (count_q == MAX_CNT);
    assign at_zero = (count_q == '0);

    // Next-state / next-count decode: rst is applied in the register block,
    // here load takes priority over counting, and DONE freezes the count.
    always_comb begin
        state_nxt    = state_q;
        count_nxt    = count_q;
        carry_nxt    = 1'b0;
        borrow_nxt   = 1'b0;
        load_err_nxt = 1'b0;

        if (load) begin
            if (load_ok) begin
                count_nxt = data_in;
                state_nxt = ST_RUN;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (en && (state_q == ST_RUN)) begin
            if (dir == CNT_UP) begin
                if (!at_max) begin
                    count_nxt = count_q + 1'b1;
                end else if (wrap_en) begin
                    count_nxt = '0;
                    carry_nxt = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end else begin
                if (!at_zero) begin
                    count_nxt = count_q - 1'b1;
                end else if (wrap_en) begin
                    count_nxt  = MAX_CNT;
                    borrow_nxt = 1'b1;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
        end
    end

    // State, count and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            count_q    <= '0;
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            count_q    <= count_nxt;
            carry_q    <= carry_nxt;
            borrow_q   <= borrow_nxt;
            load_err_q <= load_err_nxt;
        end
    end

    // tc follows mode combinationally so a direction change is visible at once.
    assign tc       = (dir == CNT_UP) ? at_max : at_zero;
    assign data_out = count_q;
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;
    assign done     = (state_q == ST_DONE);

endmodule : mod_n_updown_counter

// File: tb/tb_mod_n_updown_counter.sv
// Bench for the modulo-N up/down counter: directed vector table, hand-written
// corner sequences, and a randomised phase checked against a reference model.
module tb_mod_n_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b1;
    logic       load = 1'b0;
    logic       wrap_en = 1'b1;
    logic [3:0] data_in = '0;

    logic [3:0] data_out, data_out16;
    logic       tc, carry, borrow, load_err, done;
    logic       tc16, carry16, borrow16, load_err16, done16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(12)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .wrap_en(wrap_en), .data_in(data_in), .data_out(data_out),
        .tc(tc), .carry(carry), .borrow(borrow), .load_err(load_err),
        .done(done)
    );

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
        .wrap_en(wrap_en), .data_in(data_in), .data_out(data_out16),
        .tc(tc16), .carry(carry16), .borrow(borrow16), .load_err(load_err16),
        .done(done16)
    );

    // inputs: rst en mode load wrap din ; expected: q tc carry borrow lerr done
    typedef struct {
        string      name;
        logic       rst, en, mode, load, wrap;
        logic [3:0] din;
        logic [3:0] q;
        logic       tc, carry, borrow, lerr, done;
    } vec_t;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic e, logic m, logic l, logic w,
                                logic [3:0] d, logic [3:0] q, logic t, logic c,
                                logic b, logic le, logic dn);
        vec_t v;
        v.name = n; v.rst = r; v.en = e; v.mode = m; v.load = l; v.wrap = w; v.din = d;
        v.q = q; v.tc = t; v.carry = c; v.borrow = b; v.lerr = le; v.done = dn;
        return v;
    endfunction

    task automatic compare(string name, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got q=%0d tc=%b c=%b b=%b le=%b done=%b, want q=%0d tc=%b c=%b b=%b le=%b done=%b",
                     name, act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one vector on the falling edge, queue its expectation, and check
    // the DUT just after the rising edge that consumes it.
    task automatic apply(vec_t v);
        sb_t e;
        sb_t got;
        @(negedge clk);
        rst = v.rst; en = v.en; mode = v.mode; load = v.load; wrap_en = v.wrap; data_in = v.din;
        e.name = v.name;
        e.exp  = {v.q, v.tc, v.carry, v.borrow, v.lerr, v.done};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        compare(got.name, {data_out, tc, carry, borrow, load_err, done}, got.exp);
    endtask

    // Reference model for MODULUS=12.
    int m_cnt = 0;
    bit m_done = 0;

    task automatic model_vec(string n, logic r, logic e, logic m, logic l, logic w,
                             logic [3:0] d, output vec_t v);
        bit c = 0, b = 0, le = 0;
        if (r) begin
            m_cnt = 0; m_done = 0;
        end else if (l) begin
            if (int'(d) < 12) begin m_cnt = int'(d); m_done = 0; end
            else le = 1;
        end else if (e && !m_done) begin
            if (m) begin
                if (m_cnt == 11) begin
                    if (w) begin m_cnt = 0; c = 1; end else m_done = 1;
                end else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin
                    if (w) begin m_cnt = 11; b = 1; end else m_done = 1;
                end else m_cnt = m_cnt - 1;
            end
        end
        v = mk(n, r, e, m, l, w, d, 4'(m_cnt), m ? (m_cnt == 11) : (m_cnt == 0),
               c, b, le, m_done);
    endtask

    initial begin
        vec_t v;

        // name           rst en md ld wr din  q  tc c  b  le dn
        vecs.push_back(mk("reset",       1, 0, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t1_load6",    0, 0, 1, 1, 1, 6,  6, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t1_cnt7",     0, 1, 1, 0, 1, 0,  7, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t1_rst_ld",   1, 1, 1, 1, 1, 5,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_load11",   0, 1, 1, 1, 1, 11, 11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t2_wrap",     0, 1, 1, 0, 1, 0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("t2_after",    0, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t3_load0",    0, 1, 0, 1, 1, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t3_wrap",     0, 1, 0, 0, 1, 0,  11, 0, 0, 1, 0, 0));
        vecs.push_back(mk("t3_after",    0, 1, 0, 0, 1, 0,  10, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_load4",    0, 0, 0, 1, 1, 4,  4, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_bad13",    0, 0, 0, 1, 1, 13, 4, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t4_clear",    0, 0, 0, 0, 1, 0,  4, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_bad12_en", 0, 1, 1, 1, 1, 12, 4, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t5_load10",   0, 1, 1, 1, 0, 10, 10, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t5_cnt11",    0, 1, 1, 0, 0, 0,  11, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t5_halt",     0, 1, 1, 0, 0, 0,  11, 1, 0, 0, 0, 1));
        vecs.push_back(mk("t5_wrap_dn",  0, 1, 1, 0, 1, 0,  11, 1, 0, 0, 0, 1));
        vecs.push_back(mk("t5_mode0",    0, 1, 0, 0, 0, 0,  11, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t5_bad_dn",   0, 1, 0, 1, 0, 14, 11, 0, 0, 0, 1, 1));
        vecs.push_back(mk("t5_load3",    0, 1, 0, 1, 0, 3,  3, 0, 0, 0, 0, 0));
        vecs.push_back(mk("dn_load1",    0, 1, 0, 1, 0, 1,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("dn_cnt0",     0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("dn_halt",     0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1));
        vecs.push_back(mk("rst_in_done", 1, 1, 0, 1, 0, 7,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t6_ld_en",    0, 1, 1, 1, 1, 6,  6, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t6_hold1",    0, 0, 1, 0, 1, 0,  6, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t6_hold2",    0, 0, 1, 0, 1, 0,  6, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t6_hold3",    0, 0, 1, 0, 1, 0,  6, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t6_load0",    0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // tc must follow mode without waiting for a clock edge.
        mode = 1'b0;
        #1;
        checks++;
        if (tc !== 1'b1) begin
            failures++;
            $display("FAIL tc_comb_mode: got tc=%b want 1", tc);
        end

        // MODULUS == 2**WIDTH: 15 is a legal load and wraps up to 0 with carry.
        apply(mk("m16_rst", 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 0; en = 0; mode = 1; load = 1; wrap_en = 1; data_in = 4'd15;
        @(posedge clk); #1;
        compare("m16_load15", {data_out16, tc16, carry16, borrow16, load_err16, done16},
                {4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        load = 0; en = 1;
        @(posedge clk); #1;
        compare("m16_wrap", {data_out16, tc16, carry16, borrow16, load_err16, done16},
                {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Randomised phase against the reference model.
        model_vec("rnd_rst", 1, 0, 1, 0, 1, 0, v);
        apply(v);
        for (int i = 0; i < 400; i++) begin
            logic r, e, m, l, w;
            logic [3:0] d;
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 5) != 0) ? mode : ~mode;
            l = ($urandom_range(0, 9) == 0);
            w = ($urandom_range(0, 4) != 0);
            d = 4'($urandom_range(0, 15));
            model_vec($sformatf("rnd_%0d", i), r, e, m, l, w, d, v);
            apply(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod_n_updown_counter
